sme_host_driver: RTL and testbench
==================================

Name: sme_host_driver

Overview:
- Transmit-side counterpart of the string-matching engine's serial load/result protocol.
- Buffers one string (up to 32 chars) and one pattern (up to 8 chars) written by a controller.
- Streams them to the engine on chardata/isstring/ispattern, waits for the engine's valid pulse, then captures match/match_index into a result register.
- Re-sends the string only when it was rewritten since the last run, so several patterns can be checked against one string.

Parameters:
- STR_MAX, 32: string buffer depth; counters and write pointer are 6 bits.
- PAT_MAX, 8: pattern buffer depth; counters and write pointer are 4 bits.
- TIMEOUT, 255: maximum WAIT cycles for sme_valid before an error is flagged; 8-bit counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one char into the buffer selected by wr_sel
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer
- wr_clr  in  1  clear the write pointer of the buffer selected by wr_sel
- wr_data  in  8  char to write
- start  in  1  launch a transfer (single-cycle pulse)
- busy  out  1  high from accepted start until done
- chardata  out  8  char to the engine
- isstring  out  1  chardata is a string char
- ispattern  out  1  chardata is a pattern char
- sme_valid  in  1  engine result strobe
- sme_match  in  1  engine match flag
- sme_match_index  in  5  engine match position
- done  out  1  one-cycle pulse when the result or error is registered
- result_match  out  1  captured sme_match; held until the next done
- result_index  out  5  captured sme_match_index; held until the next done
- timeout_err  out  1  set with done if TIMEOUT expired; cleared at the next accepted start

Behaviour:
- Reset: all outputs 0; chardata = 8'h00; state IDLE; str_len = pat_len = 0; str_dirty = 0.
- Buffer writes (IDLE only; wr_en/wr_clr ignored while busy):
  - wr_clr has priority over wr_en. It zeroes the selected length; string clear also sets str_dirty.
  - A write stores at index = current length, then increments the length.
  - A string write sets str_dirty.
  - Writes at a full buffer (len == STR_MAX / PAT_MAX) are dropped; the length saturates.
- start is accepted only in IDLE with pat_len != 0. Otherwise it is ignored, with no busy and no done.
- FSM:
  - IDLE -> SEND_STR on start when str_dirty = 1 and str_len != 0; otherwise IDLE -> SEND_PAT.
  - SEND_STR: isstring = 1 and chardata = str_buf[idx] for exactly str_len consecutive cycles, idx 0..str_len-1. After the last char, go directly to SEND_PAT with no gap, and clear str_dirty.
  - SEND_PAT: ispattern = 1 for exactly pat_len cycles, same indexing. Then go to GAP.
  - GAP: one cycle with isstring = ispattern = 0 and chardata = 0. This is the engine's end-of-load marker. Then go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - sme_valid = 1: capture sme_match/sme_match_index, go to DONE.
    - Counter reaches TIMEOUT first: keep the result registers unchanged, set timeout_err, go to DONE.
  - DONE: done = 1 for one cycle, busy falls the same cycle, return to IDLE.
- isstring and ispattern are never high together. Both are 0 outside SEND_STR and SEND_PAT.
- sme_valid outside WAIT is ignored.
- busy rises in the cycle after start is sampled, i.e. the first SEND cycle.
- Latency from start to the first char: 1 cycle. Total cycles from start to done: 1 + str_len·dirty + pat_len + 1 + wait + 1.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs 0 and buffers emptied. The engine sees the stream stop, and the driver does not wait for any stale valid.
- start arriving while busy is ignored and not queued.

Test Plan:
- Write string "abc de" (6 chars) and pattern "de", then pulse start → isstring high for 6 cycles with chars 61,62,63,20,64,65 in order, ispattern high for 2 cycles (64,65), 1 idle cycle; sme_valid with match = 1, index = 4 → done pulses, result_match = 1, result_index = 4.
- Repeat start without rewriting the string, new pattern "^a" → no isstring cycles, 2 ispattern cycles; first ispattern appears 1 cycle after start.
- Hold sme_valid low with TIMEOUT = 255 → done after 255 WAIT cycles, timeout_err = 1, result registers unchanged; the next start clears timeout_err.
- Write 33 string chars → str_len = 32; the 33rd char is never transmitted. start with pat_len = 0 → no busy, no done.
- Assert reset during SEND_STR at char 3 → next cycle isstring = 0, busy = 0; a later sme_valid pulse produces no done.
- wr_en pulsed while busy → buffers unchanged, which is verified by a retransmission matching the original contents.

Source files
------------

// File: rtl/sme_host_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sme_host_driver_if
// Description : Controller write port, engine stream and result bus of the
//               string-matching-engine host driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface sme_host_driver_if;
    logic       wr_en;
    logic       wr_sel;
    logic       wr_clr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_match_index;
    logic       done;
    logic       result_match;
    logic [4:0] result_index;
    logic       timeout_err;

    // Driver side
    modport slave (
        input  wr_en, wr_sel, wr_clr, wr_data, start,
        input  sme_valid, sme_match, sme_match_index,
        output busy, chardata, isstring, ispattern,
        output done, result_match, result_index, timeout_err
    );

    // Controller / engine side
    modport master (
        output wr_en, wr_sel, wr_clr, wr_data, start,
        output sme_valid, sme_match, sme_match_index,
        input  busy, chardata, isstring, ispattern,
        input  done, result_match, result_index, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/sme_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : sme_host_driver
// Description : Buffers a string and a pattern, streams them to the matching
//               engine and registers the engine's match result.
// Revision    : 1.0 - initial release
// ============================================================================
module sme_host_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sme_host_driver_if.slave  bus
);
    localparam int c_slw = $clog2(STR_MAX + 1);
    localparam int c_plw = $clog2(PAT_MAX + 1);
    localparam int c_saw = $clog2(STR_MAX);
    localparam int c_paw = $clog2(PAT_MAX);
    localparam logic [c_slw-1:0] c_str_full = c_slw'(STR_MAX);
    localparam logic [c_plw-1:0] c_pat_full = c_plw'(PAT_MAX);
    localparam logic [7:0]       c_tmo_last = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_STR = 3'd1,
        S_SEND_PAT = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       str_buf_q [STR_MAX];
    logic [7:0]       str_buf_d [STR_MAX];
    logic [7:0]       pat_buf_q [PAT_MAX];
    logic [7:0]       pat_buf_d [PAT_MAX];
    logic [c_slw-1:0] str_len_q, str_len_d;
    logic [c_plw-1:0] pat_len_q, pat_len_d;
    logic             str_dirty_q, str_dirty_d;
    logic [c_slw-1:0] idx_q, idx_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             res_match_q, res_match_d;
    logic [4:0]       res_index_q, res_index_d;
    logic             terr_q, terr_d;

    logic             w_str_last;
    logic             w_pat_last;

    // One shared index walks both buffers; compare against len-1 for the last char
    assign w_str_last = (idx_q == str_len_q - c_slw'(1));
    assign w_pat_last = (idx_q == c_slw'(pat_len_q) - c_slw'(1));

    always_comb begin
        state_d       = state_q;
        str_buf_d     = str_buf_q;
        pat_buf_d     = pat_buf_q;
        str_len_d     = str_len_q;
        pat_len_d     = pat_len_q;
        str_dirty_d   = str_dirty_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        terr_d        = terr_q;
        bus.busy      = 1'b0;
        bus.chardata  = 8'h00;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_clr) begin
                    if (!bus.wr_sel) begin
                        str_len_d   = '0;
                        str_dirty_d = 1'b1;
                    end else begin
                        pat_len_d   = '0;
                    end
                end else if (bus.wr_en) begin
                    if (!bus.wr_sel) begin
                        str_dirty_d = 1'b1;
                        if (str_len_q != c_str_full) begin
                            str_buf_d[str_len_q[c_saw-1:0]] = bus.wr_data;
                            str_len_d = str_len_q + c_slw'(1);
                        end
                    end else if (pat_len_q != c_pat_full) begin
                        pat_buf_d[pat_len_q[c_paw-1:0]] = bus.wr_data;
                        pat_len_d = pat_len_q + c_plw'(1);
                    end
                end
                if (bus.start && (pat_len_q != '0)) begin
                    terr_d  = 1'b0;
                    idx_d   = '0;
                    state_d = (str_dirty_q && (str_len_q != '0)) ? S_SEND_STR : S_SEND_PAT;
                end
            end
            S_SEND_STR: begin
                bus.busy     = 1'b1;
                bus.isstring = 1'b1;
                bus.chardata = str_buf_q[idx_q[c_saw-1:0]];
                if (w_str_last) begin
                    idx_d       = '0;
                    str_dirty_d = 1'b0;
                    state_d     = S_SEND_PAT;
                end else begin
                    idx_d = idx_q + c_slw'(1);
                end
            end
            S_SEND_PAT: begin
                bus.busy      = 1'b1;
                bus.ispattern = 1'b1;
                bus.chardata  = pat_buf_q[idx_q[c_paw-1:0]];
                if (w_pat_last) begin
                    idx_d   = '0;
                    state_d = S_GAP;
                end else begin
                    idx_d = idx_q + c_slw'(1);
                end
            end
            S_GAP: begin
                bus.busy = 1'b1;
                tmo_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                if (bus.sme_valid) begin
                    res_match_d = bus.sme_match;
                    res_index_d = bus.sme_match_index;
                    state_d     = S_DONE;
                end else if (tmo_q == c_tmo_last) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            str_buf_q   <= '{default: '0};
            pat_buf_q   <= '{default: '0};
            str_len_q   <= '0;
            pat_len_q   <= '0;
            str_dirty_q <= 1'b0;
            idx_q       <= '0;
            tmo_q       <= '0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            str_buf_q   <= str_buf_d;
            pat_buf_q   <= pat_buf_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            str_dirty_q <= str_dirty_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            terr_q      <= terr_d;
        end
    end

    assign bus.result_match = res_match_q;
    assign bus.result_index = res_index_q;
    assign bus.timeout_err  = terr_q;
endmodule
`default_nettype wire

// File: tb/tb_sme_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sme_host_driver
// Description : Scoreboard bench for sme_host_driver: directed loads/runs push
//               expected stream and result events, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_host_driver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_host_driver_if bus();

    sme_host_driver #(
        .STR_MAX(32),
        .PAT_MAX(8),
        .TIMEOUT(255)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0] kind;   // 0 string char, 1 pattern char, 2 done
        logic [7:0] data;
        logic       m;
        logic [4:0] idx;
        logic       terr;
    } exp_t;

    exp_t       sb[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic       exp_m     = 1'b0;
    logic [4:0] exp_idx   = 5'd0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endfunction

    function automatic void flag(string name);
        total_cnt++;
        $display("FAIL %s: unexpected DUT activity at %0t", name, $time);
    endfunction

    // Monitor: every char and every done must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus.isstring && bus.ispattern) flag("isstring_and_ispattern");
        if (bus.isstring || bus.ispattern) begin
            if (sb.size() == 0) flag("unexpected_char");
            else begin
                e = sb.pop_front();
                chk("char_kind", {31'd0, bus.ispattern}, {30'd0, e.kind});
                chk("char_data", {24'd0, bus.chardata}, {24'd0, e.data});
            end
        end
        if (bus.done) begin
            if (sb.size() == 0) flag("unexpected_done");
            else begin
                e = sb.pop_front();
                chk("done_kind", 32'd2, {30'd0, e.kind});
                chk("result_match", {31'd0, bus.result_match}, {31'd0, e.m});
                chk("result_index", {27'd0, bus.result_index}, {27'd0, e.idx});
                chk("timeout_err", {31'd0, bus.timeout_err}, {31'd0, e.terr});
                chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic exp_str(input logic [1:0] kind, input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back('{kind, s[i], 1'b0, 5'd0, 1'b0});
    endtask

    task automatic load(input logic sel, input string s);
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_clr = 1'b1; bus.wr_sel = sel;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.wr_clr = 1'b0; bus.wr_en = 1'b1; bus.wr_data = s[i];
        end
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_clr = 1'b0;
    endtask

    // One transfer: start, stray valid during SEND, optional busy-time writes,
    // valid in the first WAIT cycle (or none), then bounded wait for done.
    task automatic run(input int ns, input int np, input bit give_valid,
                       input logic m, input logic [4:0] idx, input bit inject);
        int cnt = 0;
        bit seen = 0;
        int wait_at = ns + np + 2;
        if (give_valid) begin exp_m = m; exp_idx = idx; end
        sb.push_back('{2'd2, 8'h00, exp_m, exp_idx, !give_valid});
        @(negedge clk);
        bus.start = 1'b1;
        while (!seen && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                bus.start = 1'b0;
                chk("busy_first_cycle", {31'd0, bus.busy}, 32'd1);
                chk("isstring_first", {31'd0, bus.isstring}, (ns > 0) ? 32'd1 : 32'd0);
                chk("ispattern_first", {31'd0, bus.ispattern}, (ns == 0) ? 32'd1 : 32'd0);
                chk("terr_cleared", {31'd0, bus.timeout_err}, 32'd0);
                bus.sme_valid = 1'b1; bus.sme_match = ~m; bus.sme_match_index = ~idx;
            end
            if (cnt == 2) begin
                bus.sme_valid = 1'b0; bus.sme_match = 1'b1; bus.sme_match_index = 5'd31;
            end
            if (inject && cnt == 2) begin bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 8'hFF; end
            if (inject && cnt == 3) begin bus.wr_en = 1'b0; bus.wr_clr = 1'b1; bus.wr_sel = 1'b1; end
            if (inject && cnt == 4) bus.wr_clr = 1'b0;
            if (cnt == wait_at && give_valid) begin
                bus.sme_valid = 1'b1; bus.sme_match = m; bus.sme_match_index = idx;
            end
            if (cnt == wait_at + 1) begin
                bus.sme_valid = 1'b0; bus.sme_match = 1'b1; bus.sme_match_index = 5'd31;
            end
            if (bus.done) seen = 1;
        end
        chk("start_to_done_cycles", cnt, ns + np + 2 + (give_valid ? 1 : 255));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        bit   seen;
        string ramp;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_clr = 0; bus.wr_data = 0; bus.start = 0;
        bus.sme_valid = 0; bus.sme_match = 1; bus.sme_match_index = 5'd31;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_isstring", {31'd0, bus.isstring}, 32'd0);
        chk("rst_ispattern", {31'd0, bus.ispattern}, 32'd0);
        chk("rst_chardata", {24'd0, bus.chardata}, 32'd0);
        chk("rst_result_match", {31'd0, bus.result_match}, 32'd0);
        chk("rst_result_index", {27'd0, bus.result_index}, 32'd0);
        chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        reset = 1'b0;

        // Full transfer: string 61 62 63 20 64 65, pattern 64 65, match at 4
        load(1'b0, "abc de");
        load(1'b1, "de");
        exp_str(2'd0, "abc de");
        exp_str(2'd1, "de");
        run(6, 2, 1, 1'b1, 5'd4, 0);

        // Same string, new pattern: no string resend
        load(1'b1, "^a");
        exp_str(2'd1, "^a");
        run(0, 2, 1, 1'b0, 5'd0, 0);

        // Timeout: result held, timeout_err set
        exp_str(2'd1, "^a");
        run(0, 2, 0, 1'b0, 5'd0, 0);

        // Next start clears timeout_err; writes while busy must be ignored
        exp_str(2'd1, "^a");
        run(0, 2, 1, 1'b1, 5'd2, 1);
        exp_str(2'd1, "^a");
        run(0, 2, 1, 1'b0, 5'd7, 0);

        // 33 string writes saturate at 32; start with empty pattern is ignored
        ramp = "";
        for (int i = 0; i < 33; i++) ramp = {ramp, string'(8'h40 + 8'(i))};
        load(1'b0, ramp);
        load(1'b1, "");
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        seen = 0;
        repeat (6) begin
            if (bus.busy || bus.done) seen = 1;
            @(negedge clk);
        end
        chk("start_without_pattern", {31'd0, seen}, 32'd0);
        load(1'b1, "x");
        exp_str(2'd0, ramp.substr(0, 31));
        exp_str(2'd1, "x");
        run(32, 1, 1, 1'b1, 5'd31, 0);

        // Reset while char at index 3 is on the bus
        load(1'b0, "abcdef");
        exp_str(2'd0, "abcd");
        @(negedge clk); bus.start = 1'b1;
        cnt = 0;
        while (cnt < 4) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_isstring", {31'd0, bus.isstring}, 32'd0);
        chk("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_reset_chardata", {24'd0, bus.chardata}, 32'd0);
        chk("mid_reset_result_match", {31'd0, bus.result_match}, 32'd0);
        exp_m = 1'b0; exp_idx = 5'd0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            bus.sme_valid = (i == 2);
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        bus.sme_valid = 1'b0;
        chk("no_done_after_reset", {31'd0, seen}, 32'd0);

        // Buffers emptied by reset: pattern-only transfer works
        load(1'b1, "z");
        exp_str(2'd1, "z");
        run(0, 1, 1, 1'b0, 5'd3, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
